// File: rtl/io_host_bridge_pkg.sv
// Shared constants, FSM state type and helpers for io_host_bridge.
package io_bridge_pkg;

    localparam int WORD_W        = 16;
    localparam int OUT_TGL_BIT   = 15;
    localparam int ACK_TGL_BIT   = 14;
    localparam int IN_PAYLOAD_W  = 15;
    localparam int OUT_PAYLOAD_W = 14;

    typedef enum logic [1:0] {
        PRIME,
        IDLE,
        WAIT_ACK
    } in_state_e;

    // Saturating 8-bit increment for the dropped-word counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/io_host_bridge_if.sv
// Processor-pin and host-stream bundle for io_host_bridge.
// Overflow status signals exist only when IO_HOST_BRIDGE_OVF_EN is defined.
interface io_host_bridge_if #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
);
    import io_bridge_pkg::*;

    localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;

    logic [WORD_W-1:0]        write_out;
    logic [WORD_W-1:0]        read_in;
    logic [IN_PAYLOAD_W-1:0]  host_in_data;
    logic                     host_in_valid;
    logic                     host_in_ready;
    logic [OUT_PAYLOAD_W-1:0] host_out_data;
    logic                     host_out_valid;
    logic                     host_out_ready;
    logic [IN_LW-1:0]         in_level;
    logic [OUT_LW-1:0]        out_level;

`ifdef IO_HOST_BRIDGE_OVF_EN
    logic                     ovf_sticky;
    logic [7:0]               drop_count;

    modport slave (
        input  write_out, host_in_data, host_in_valid, host_out_ready,
        output read_in, host_in_ready, host_out_data, host_out_valid,
               in_level, out_level, ovf_sticky, drop_count
    );
    modport master (
        output write_out, host_in_data, host_in_valid, host_out_ready,
        input  read_in, host_in_ready, host_out_data, host_out_valid,
               in_level, out_level, ovf_sticky, drop_count
    );
`else
    modport slave (
        input  write_out, host_in_data, host_in_valid, host_out_ready,
        output read_in, host_in_ready, host_out_data, host_out_valid,
               in_level, out_level
    );
    modport master (
        output write_out, host_in_data, host_in_valid, host_out_ready,
        input  read_in, host_in_ready, host_out_data, host_out_valid,
               in_level, out_level
    );
`endif

endinterface

// File: rtl/io_host_bridge_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only alongside a pop.
module sync_fifo_component #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the array is deliberately not reset; empty masks rd_data, so stale words are never visible.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/io_host_bridge.sv
// Host-side mailbox agent for the processor's memory-mapped I/O word pair.
// Optional overflow status is compiled in with IO_HOST_BRIDGE_OVF_EN.
module io_host_bridge #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    io_host_bridge_if.slave  bus
);
    import io_bridge_pkg::*;

    in_state_e                state;
    in_state_e                state_nxt;
    logic [WORD_W-1:0]        wo_q;
    logic                     pres_tgl;
    logic [IN_PAYLOAD_W-1:0]  pres_data;

    logic                     in_push, in_pop, in_full, in_empty;
    logic [IN_PAYLOAD_W-1:0]  in_head;
    logic                     out_event, out_pop, out_full, out_empty;

    // Only the toggle bit of wo_q is compared; the rest is a plain snapshot.
    logic                     unused_wo_bits;
    assign unused_wo_bits = ^wo_q[ACK_TGL_BIT:0];

    assign in_push            = bus.host_in_valid && !in_full;
    assign bus.host_in_ready  = !in_full;
    assign bus.read_in        = {pres_tgl, pres_data};

    assign out_pop            = bus.host_out_ready && !out_empty;
    assign bus.host_out_valid = !out_empty;
    assign out_event          = (state != PRIME) &&
                                (bus.write_out[OUT_TGL_BIT] != wo_q[OUT_TGL_BIT]);

    sync_fifo_component #(.WIDTH(IN_PAYLOAD_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clock   (clock),
        .rst     (rst),
        .push    (in_push),
        .pop     (in_pop),
        .wr_data (bus.host_in_data),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty),
        .level   (bus.in_level)
    );

    sync_fifo_component #(.WIDTH(OUT_PAYLOAD_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clock   (clock),
        .rst     (rst),
        .push    (out_event),
        .pop     (out_pop),
        .wr_data (bus.write_out[OUT_PAYLOAD_W-1:0]),
        .rd_data (bus.host_out_data),
        .full    (out_full),
        .empty   (out_empty),
        .level   (bus.out_level)
    );

    // Previous processor word, used for output-toggle edge detection.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) wo_q <= '0;
        else     wo_q <= bus.write_out;
    end

    // Input FSM state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= PRIME;
        else     state <= state_nxt;
    end

    // Input FSM next-state: prime once, then present a word and wait for its ack.
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:    state_nxt = IDLE;
            IDLE:     if (!in_empty) state_nxt = WAIT_ACK;
            WAIT_ACK: if (bus.write_out[ACK_TGL_BIT] == pres_tgl) state_nxt = IDLE;
            default:  state_nxt = PRIME;
        endcase
    end

    // Input FSM outputs: pop the head when a new presentation starts.
    always_comb begin
        in_pop = (state == IDLE) && !in_empty;
    end

    // Presented word and its toggle; each new word flips the toggle.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pres_tgl  <= 1'b0;
            pres_data <= '0;
        end else if (in_pop) begin
            pres_tgl  <= ~pres_tgl;
            pres_data <= in_head;
        end
    end

`ifdef IO_HOST_BRIDGE_OVF_EN
    logic       out_drop;
    logic       ovf_q;
    logic [7:0] drop_q;

    assign out_drop       = out_event && out_full && !out_pop;
    assign bus.ovf_sticky = ovf_q;
    assign bus.drop_count = drop_q;

    // Sticky overflow flag and saturating count of dropped output words.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (out_drop) begin
            ovf_q  <= 1'b1;
            drop_q <= sat_inc8(drop_q);
        end
    end
`else
    // Without status reporting, a full-FIFO event simply loses its word.
    logic unused_out_full;
    assign unused_out_full = out_full;
`endif

endmodule

// File: tb/tb_io_host_bridge.sv
// Self-checking bench for io_host_bridge: queue-based reference model,
// per-cycle comparison, directed scenarios and a randomized phase.
module tb_io_host_bridge;
    import io_bridge_pkg::*;

    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    io_host_bridge_if #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) bus ();

    io_host_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queues of words plus the mailbox state seen by the processor.
    logic [14:0] m_in_q[$];
    logic [13:0] m_out_q[$];
    logic        m_tgl;
    logic [14:0] m_data;
    bit          m_wait;
    bit          m_prime;
    logic        m_prev_tgl;
    bit          m_acc_last;
    bit          m_ovf;
    int          m_drops;
    bit          cmp_en = 0;

    task automatic model_reset();
        m_in_q.delete();
        m_out_q.delete();
        m_tgl      = 1'b0;
        m_data     = '0;
        m_wait     = 0;
        m_prime    = 1;
        m_prev_tgl = 1'b0;
        m_acc_last = 0;
        m_ovf      = 0;
        m_drops    = 0;
    endtask

    task automatic model_step();
        bit acc, pop_o, ev;
        acc   = bus.host_in_valid && (m_in_q.size() < IN_DEPTH);
        pop_o = bus.host_out_ready && (m_out_q.size() != 0);
        ev    = !m_prime && (bus.write_out[15] != m_prev_tgl);
        if (m_prime) begin
            m_prime = 0;
        end else if (m_wait) begin
            if (bus.write_out[14] == m_tgl) m_wait = 0;
        end else if (m_in_q.size() != 0) begin
            m_data = m_in_q.pop_front();
            m_tgl  = ~m_tgl;
            m_wait = 1;
        end
        if (pop_o) m_out_q.delete(0);
        if (ev) begin
            if (m_out_q.size() < OUT_DEPTH) begin
                m_out_q.push_back(bus.write_out[13:0]);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_prev_tgl = bus.write_out[15];
        if (acc) m_in_q.push_back(bus.host_in_data);
        m_acc_last = acc;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("read_in", bus.read_in, {m_tgl, m_data});
            check("host_in_ready", bus.host_in_ready, m_in_q.size() < IN_DEPTH);
            check("in_level", bus.in_level, m_in_q.size());
            check("out_level", bus.out_level, m_out_q.size());
            check("host_out_valid", bus.host_out_valid, m_out_q.size() != 0);
            if (m_out_q.size() != 0) check("host_out_data", bus.host_out_data, m_out_q[0]);
`ifdef IO_HOST_BRIDGE_OVF_EN
            check("ovf_sticky", bus.ovf_sticky, m_ovf);
            check("drop_count", bus.drop_count, m_drops);
`endif
        end
    end

    logic tgl_o;
    logic ack_o;

    task automatic set_wo(input logic [13:0] payload);
        bus.write_out = {tgl_o, ack_o, payload};
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!rst) model_step();
        @(negedge clock);
    endtask

    initial begin
        int rdy_pct;
        bus.host_in_valid  = 1'b0;
        bus.host_in_data   = '0;
        bus.host_out_ready = 1'b0;
        tgl_o = 1'b1;
        ack_o = 1'b0;
        bus.write_out = 16'h8000;

        // Reset values, with write_out=8000 held through release.
        #1 rst = 1'b1;
        model_reset();
        cmp_en = 1;
        repeat (2) @(negedge clock);
        check("rst read_in", bus.read_in, 16'h0000);
        check("rst host_in_ready", bus.host_in_ready, 1);
        check("rst host_out_valid", bus.host_out_valid, 0);
        check("rst host_out_data", bus.host_out_data, 0);
        check("rst in_level", bus.in_level, 0);
        check("rst out_level", bus.out_level, 0);
        rst = 1'b0;

        // PRIME immunity.
        repeat (3) cycle();
        check("prime out_level", bus.out_level, 0);
        check("prime out_valid", bus.host_out_valid, 0);

        // Single input and ack.
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 15'h1234;
        cycle();
        bus.host_in_valid = 1'b0;
        cycle();
        check("single read_in", bus.read_in, 16'h9234);
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 15'h0055;
        cycle();
        bus.host_in_valid = 1'b0;
        check("queued in_level", bus.in_level, 1);
        ack_o = 1'b1;
        set_wo(14'h0);
        cycle();
        check("ack cycle read_in", bus.read_in, 16'h9234);
        cycle();
        check("next word read_in", bus.read_in, 16'h0055);
        check("next word in_level", bus.in_level, 0);
        ack_o = 1'b0;
        set_wo(14'h0);
        cycle();

        // Input backpressure: five words, no ack for the presented one.
        for (int i = 0; i < 5; i++) begin
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = 15'(16'h0100 + i);
            cycle();
        end
        check("bp in_level", bus.in_level, 4);
        check("bp host_in_ready", bus.host_in_ready, 0);
        check("bp read_in", bus.read_in, 16'h8100);
        bus.host_in_data = 15'h0105;
        repeat (3) cycle();
        check("bp stall in_level", bus.in_level, 4);
        ack_o = 1'b1;
        set_wo(14'h0);
        cycle();
        check("bp ack in_level", bus.in_level, 4);
        cycle();
        check("bp second word", bus.read_in, 16'h0101);
        check("bp no bypass", bus.in_level, 3);
        cycle();
        bus.host_in_valid = 1'b0;
        check("bp sixth accepted", bus.in_level, 4);
        for (int i = 0; i < 10; i++) begin
            ack_o = bus.read_in[15];
            set_wo(14'h0);
            cycle();
        end
        check("bp drained", bus.in_level, 0);

        // Output toggles with the host stalled.
        tgl_o = ~tgl_o; set_wo(14'h0001); cycle();
        tgl_o = ~tgl_o; set_wo(14'h0002); cycle();
        tgl_o = ~tgl_o; set_wo(14'h0003); cycle();
        check("out3 level", bus.out_level, 3);
        check("out3 head1", bus.host_out_data, 14'h0001);
        bus.host_out_ready = 1'b1;
        cycle();
        check("out3 head2", bus.host_out_data, 14'h0002);
        cycle();
        check("out3 head3", bus.host_out_data, 14'h0003);
        cycle();
        check("out3 empty", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;

        // Overflow: six toggles, no pops.
        for (int i = 0; i < 6; i++) begin
            tgl_o = ~tgl_o;
            set_wo(14'(16'h0010 + i));
            cycle();
        end
        check("ovf level", bus.out_level, 4);
        check("ovf head", bus.host_out_data, 14'h0010);
`ifdef IO_HOST_BRIDGE_OVF_EN
        check("ovf drop_count", bus.drop_count, 2);
        check("ovf sticky", bus.ovf_sticky, 1);
`endif
        bus.host_out_ready = 1'b1;
        repeat (4) cycle();
        check("ovf drained", bus.out_level, 0);

        // Overflow again, with a pop in the fifth-toggle cycle.
        for (int i = 0; i < 6; i++) begin
            bus.host_out_ready = (i == 4);
            tgl_o = ~tgl_o;
            set_wo(14'(16'h0020 + i));
            cycle();
        end
        bus.host_out_ready = 1'b0;
        check("ovf2 level", bus.out_level, 4);
        check("ovf2 head", bus.host_out_data, 14'h0021);
`ifdef IO_HOST_BRIDGE_OVF_EN
        check("ovf2 drop_count", bus.drop_count, 3);
`endif
        bus.host_out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic; host-ready bias alternates to reach full and empty.
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = ((c / 400) % 2 == 0) ? 20 : 85;
            if (!bus.host_in_valid || m_acc_last) begin
                bus.host_in_valid = ($urandom_range(0, 99) < 60);
                bus.host_in_data  = 15'($urandom);
            end
            bus.host_out_ready = ($urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 99) < 40) tgl_o = ~tgl_o;
            if ($urandom_range(0, 99) < 30) ack_o = ~ack_o;
            set_wo(14'($urandom));
            cycle();
        end

        // Reset mid-WAIT_ACK with two words queued.
        bus.host_in_valid  = 1'b0;
        bus.host_out_ready = 1'b0;
        ack_o = 1'b0;
        set_wo(14'h0);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.host_in_valid = 1'b1;
            bus.host_in_data  = 15'(16'h0200 + i);
            cycle();
        end
        bus.host_in_valid = 1'b0;
        check("mid in_level", bus.in_level, 2);
        check("mid read_in", bus.read_in, 16'h8200);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async read_in", bus.read_in, 16'h0000);
        check("async in_level", bus.in_level, 0);
        check("async host_in_ready", bus.host_in_ready, 1);
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack_o = ~ack_o;
            set_wo(14'h0);
            cycle();
        end
        check("no stale read_in", bus.read_in, 16'h0000);
        check("no stale in_level", bus.in_level, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
